// File: rtl/pdp8_pkg.sv
// Shared PDP-8 memory-bus types: word type, arbiter state encoding and
// small arithmetic helpers used by the bus arbiter.
package pdp8_pkg;

  localparam int WORD_W = 12;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  localparam word_t WORD_ZERO = 12'o0000;

  function automatic logic [3:0] sat_inc4(input logic [3:0] value);
    if (value == 4'd15) begin
      sat_inc4 = 4'd15;
    end else begin
      sat_inc4 = value + 4'd1;
    end
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Shares the PDP-8 memory bus between the CPU and the data-break channel:
// fixed data-break priority, bounded data-break bursts, memory timeout.
module mem_arbiter
  import pdp8_pkg::*;
#(
  parameter int unsigned MAX_DB_BURST = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic  clk,
  input  logic  nrst,
  input  word_t cpu_address,
  input  word_t cpu_write_data,
  input  logic  cpu_write_enable,
  input  logic  cpu_mem_load,
  output word_t cpu_read_data,
  output logic  cpu_mem_ready,
  input  word_t db_address,
  input  word_t db_write_data,
  input  logic  db_write_enable,
  input  logic  db_mem_load,
  output word_t db_read_data,
  output logic  db_mem_ready,
  output word_t address,
  output word_t write_data,
  output logic  write_enable,
  output logic  mem_load,
  input  word_t read_data,
  input  logic  mem_ready,
  output logic  busy,
  output logic  grant_db,
  output logic  timeout_err
);

  localparam logic [3:0] BURST_LIM = 4'(MAX_DB_BURST);
  localparam logic [8:0] TMO_LIM   = 9'(TIMEOUT);

  arb_state_t state_r;
  arb_state_t state_s;
  logic [3:0] burst_r;
  logic [7:0] tcnt_r;

  logic pick_db_s;
  logic grant_s;
  logic tmo_s;
  logic finish_s;
  logic mem_load_s;
  logic busy_s;
  logic cpu_rdy_s;
  logic db_rdy_s;
  logic tmo_err_s;

  assign grant_s = (state_r == IDLE) && (cpu_mem_load || db_mem_load);
  assign tmo_s   = (({1'b0, tcnt_r} + 9'd1) == TMO_LIM);

  // Winner selection: data break first, unless it has starved a waiting CPU long enough
  always_comb begin
    pick_db_s = 1'b0;
    if (db_mem_load && cpu_mem_load) begin
      pick_db_s = (burst_r != BURST_LIM);
    end else begin
      pick_db_s = db_mem_load;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (cpu_mem_load || db_mem_load) begin
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: state_s = WAIT;
      WAIT: begin
        if (mem_ready || tmo_s) begin
          state_s = DONE;
        end else begin
          state_s = WAIT;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // FSM outputs: next values of the registered handshake and status lines
  always_comb begin
    finish_s   = (state_r == WAIT) && (mem_ready || tmo_s);
    mem_load_s = (state_s == ISSUE);
    busy_s     = (state_s != IDLE);
    cpu_rdy_s  = finish_s && !grant_db;
    db_rdy_s   = finish_s && grant_db;
    tmo_err_s  = finish_s && !mem_ready;
  end

  // Registered outputs, memory-side request, burst counter and timeout counter
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mem_load      <= 1'b0;
      busy          <= 1'b0;
      cpu_mem_ready <= 1'b0;
      db_mem_ready  <= 1'b0;
      timeout_err   <= 1'b0;
      grant_db      <= 1'b0;
      address       <= WORD_ZERO;
      write_data    <= WORD_ZERO;
      write_enable  <= 1'b0;
      cpu_read_data <= WORD_ZERO;
      db_read_data  <= WORD_ZERO;
      burst_r       <= 4'd0;
      tcnt_r        <= 8'd0;
    end else begin
      mem_load      <= mem_load_s;
      busy          <= busy_s;
      cpu_mem_ready <= cpu_rdy_s;
      db_mem_ready  <= db_rdy_s;
      timeout_err   <= tmo_err_s;

      if (grant_s) begin
        grant_db <= pick_db_s;
        if (pick_db_s) begin
          address      <= db_address;
          write_data   <= db_write_data;
          write_enable <= db_write_enable;
          burst_r      <= cpu_mem_load ? sat_inc4(burst_r) : 4'd0;
        end else begin
          address      <= cpu_address;
          write_data   <= cpu_write_data;
          write_enable <= cpu_write_enable;
          burst_r      <= 4'd0;
        end
      end

      if (state_r == ISSUE) begin
        tcnt_r <= 8'd0;
      end else if (state_r == WAIT) begin
        tcnt_r <= tcnt_r + 8'd1;
      end

      // An aborted transaction returns zero rather than whatever is on the bus
      if (finish_s) begin
        if (grant_db) begin
          db_read_data <= mem_ready ? read_data : WORD_ZERO;
        end else begin
          cpu_read_data <= mem_ready ? read_data : WORD_ZERO;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: bench-side memory and requesters, a grant
// model from the arbitration rules, and a separate monitor checking every ready.
module tb_mem_arbiter;
  import pdp8_pkg::*;

  localparam int MAXB  = 4;
  localparam int TMO   = 8;
  localparam int NEVER = 99;

  logic  clk = 1'b0;
  logic  nrst;
  word_t cpu_address, cpu_write_data, cpu_read_data;
  logic  cpu_write_enable, cpu_mem_load, cpu_mem_ready;
  word_t db_address, db_write_data, db_read_data;
  logic  db_write_enable, db_mem_load, db_mem_ready;
  word_t address, write_data, read_data;
  logic  write_enable, mem_load, mem_ready, busy, grant_db, timeout_err;

  mem_arbiter #(.MAX_DB_BURST(MAXB), .TIMEOUT(TMO)) dut (
    .clk(clk), .nrst(nrst),
    .cpu_address(cpu_address), .cpu_write_data(cpu_write_data),
    .cpu_write_enable(cpu_write_enable), .cpu_mem_load(cpu_mem_load),
    .cpu_read_data(cpu_read_data), .cpu_mem_ready(cpu_mem_ready),
    .db_address(db_address), .db_write_data(db_write_data),
    .db_write_enable(db_write_enable), .db_mem_load(db_mem_load),
    .db_read_data(db_read_data), .db_mem_ready(db_mem_ready),
    .address(address), .write_data(write_data), .write_enable(write_enable),
    .mem_load(mem_load), .read_data(read_data), .mem_ready(mem_ready),
    .busy(busy), .grant_db(grant_db), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {logic db; word_t rd; logic to; int cyc;} exp_t;
  typedef struct {logic db; word_t addr; word_t wd; logic we;} grant_t;

  exp_t   exp_q[$];
  grant_t glog[$];
  int     rd_idx = 0;
  int     errors = 0;
  int     checks = 0;
  word_t  mem[4096];

  logic   mem_busy = 1'b0, mem_never = 1'b0, ml_prev = 1'b0, gdb_any = 1'b0;
  int     mem_cnt = 0, streak = 0, forced_lat = 0;
  word_t  mem_rdata;
  int     cpu_mode = 0, db_mode = 0;   // 0 off, 1 random, 2 continuous
  int     cpu_done = 0, db_done = 0, to_cnt = 0;
  word_t  last_cpu_rd, last_db_rd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [54:0] all_outs();
    return {cpu_read_data, cpu_mem_ready, db_read_data, db_mem_ready, address,
            write_data, write_enable, mem_load, busy, grant_db, timeout_err};
  endfunction

  task automatic new_cpu();
    cpu_address      = word_t'($urandom_range(0, 31));
    cpu_write_data   = word_t'($urandom);
    cpu_write_enable = 1'($urandom_range(0, 1));
    cpu_mem_load     = 1'b1;
  endtask

  task automatic new_db();
    db_address      = word_t'($urandom_range(0, 31));
    db_write_data   = word_t'($urandom);
    db_write_enable = 1'($urandom_range(0, 1));
    db_mem_load     = 1'b1;
  endtask

  // One clock: memory model, grant model + expectation push, then requesters.
  task automatic tick();
    logic sc, sd, scw, sdw, nev;
    word_t sca, scd, sda, sdd;
    grant_t g;
    exp_t e;
    int lat;
    @(posedge clk);
    sc = cpu_mem_load; sca = cpu_address; scd = cpu_write_data; scw = cpu_write_enable;
    sd = db_mem_load;  sda = db_address;  sdd = db_write_data;  sdw = db_write_enable;
    #1;
    if (!nrst) begin
      mem_busy = 1'b0; mem_ready = 1'b0; streak = 0; ml_prev = 1'b0;
    end else begin
      mem_ready = 1'b0;
      read_data = word_t'($urandom);
      if (mem_busy) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          mem_busy = 1'b0;
          if (!mem_never) begin
            mem_ready = 1'b1;
            read_data = mem_rdata;
          end
        end
      end
      if (mem_load) check("mem_load_one_cycle", ml_prev, 1'b0);
      if (mem_load && !ml_prev) begin
        check("request_present", sc || sd, 1'b1);
        check("memory_free_at_load", mem_busy, 1'b0);
        g.db = sd && !(sc && streak == MAXB);
        if (g.db) begin
          g.addr = sda; g.wd = sdd; g.we = sdw;
          streak = sc ? ((streak < 15) ? streak + 1 : 15) : 0;
        end else begin
          g.addr = sca; g.wd = scd; g.we = scw;
          streak = 0;
        end
        glog.push_back(g);
        check("grant_db", grant_db, g.db);
        check("mem_address", address, g.addr);
        check("mem_write_data", write_data, g.wd);
        check("mem_write_enable", write_enable, g.we);
        check("busy_in_issue", busy, 1'b1);
        if (forced_lat == 0) lat = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(1, 6));
        else lat = forced_lat;
        nev = (lat == NEVER);
        e.db = g.db;
        e.to = nev;
        if (nev) e.rd = 12'o0000;
        else if (g.we) e.rd = g.wd;
        else e.rd = mem[g.addr];
        if (g.we && !nev) mem[g.addr] = g.wd;
        e.cyc = cyc + (nev ? TMO : lat) + 1;
        exp_q.push_back(e);
        mem_busy = 1'b1; mem_never = nev; mem_cnt = nev ? TMO : lat; mem_rdata = e.rd;
        // stray ready during the issue cycle must be ignored
        if (!nev && lat >= 2 && forced_lat == 0 && $urandom_range(0, 3) == 0) mem_ready = 1'b1;
      end
      ml_prev = mem_load;
    end
    if (grant_db) gdb_any = 1'b1;
    if (timeout_err) to_cnt++;
    if (cpu_mem_ready) begin
      last_cpu_rd = cpu_read_data; cpu_done++;
      if (cpu_mode == 2) new_cpu(); else cpu_mem_load = 1'b0;
    end else if (!cpu_mem_load && cpu_mode == 1 && $urandom_range(0, 3) == 0) new_cpu();
    if (db_mem_ready) begin
      last_db_rd = db_read_data; db_done++;
      if (db_mode == 2) new_db(); else db_mem_load = 1'b0;
    end else if (!db_mem_load && db_mode == 1 && $urandom_range(0, 3) == 0) new_db();
  endtask

  // Monitor: every ready/timeout pulse pops the next expected completion.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!nrst) begin
        rd_idx = exp_q.size();
      end else if (cpu_mem_ready || db_mem_ready || timeout_err) begin
        if (rd_idx >= exp_q.size()) begin
          check("unexpected_ready", {cpu_mem_ready, db_mem_ready, timeout_err}, 3'b000);
        end else begin
          e = exp_q[rd_idx];
          rd_idx++;
          check("ready_owner", {cpu_mem_ready, db_mem_ready}, e.db ? 2'b01 : 2'b10);
          check("read_data", e.db ? db_read_data : cpu_read_data, e.rd);
          check("timeout_err", timeout_err, e.to);
          check("ready_cycle", cyc, e.cyc);
          check("grant_db_at_ready", grant_db, e.db);
        end
      end
    end
  end

  initial begin
    int gb, d0, t0;
    nrst = 1'b0;
    cpu_address = '0; cpu_write_data = '0; cpu_write_enable = 1'b0; cpu_mem_load = 1'b0;
    db_address = '0; db_write_data = '0; db_write_enable = 1'b0; db_mem_load = 1'b0;
    mem_ready = 1'b0; read_data = '0;
    for (int i = 0; i < 4096; i++) mem[i] = word_t'($urandom);
    repeat (3) tick();
    check("reset_outputs", all_outs(), 55'd0);
    nrst = 1'b1;
    tick();

    // Lone CPU read, fixed latency of 2
    mem[12'o0200] = 12'o7402; forced_lat = 2; gdb_any = 1'b0;
    gb = glog.size(); d0 = cpu_done;
    cpu_address = 12'o0200; cpu_write_enable = 1'b0; cpu_write_data = 12'o0000; cpu_mem_load = 1'b1;
    repeat (10) tick();
    check("p1_ready_pulses", cpu_done - d0, 1);
    check("p1_grants", glog.size() - gb, 1);
    check("p1_grant_db_seen", gdb_any, 1'b0);
    check("p1_read_data", last_cpu_rd, 12'o7402);

    // Simultaneous CPU read and data-break write
    forced_lat = 0; gb = glog.size();
    cpu_address = 12'o0300; cpu_write_enable = 1'b0; cpu_mem_load = 1'b1;
    db_address = 12'o0010; db_write_data = 12'o1234; db_write_enable = 1'b1; db_mem_load = 1'b1;
    repeat (40) tick();
    check("p2_grants", glog.size() - gb, 2);
    if (glog.size() >= gb + 2) begin
      check("p2_first_is_db", glog[gb].db, 1'b1);
      check("p2_db_we", glog[gb].we, 1'b1);
      check("p2_db_wdata", glog[gb].wd, 12'o1234);
      check("p2_db_addr", glog[gb].addr, 12'o0010);
      check("p2_second_is_cpu", glog[gb+1].db, 1'b0);
    end

    // Both ports requesting continuously: burst cap pattern
    gb = glog.size(); cpu_mode = 2; db_mode = 2;
    new_cpu(); new_db();
    for (int i = 0; i < 400 && glog.size() < gb + 10; i++) tick();
    check("p3_grant_count", glog.size() >= gb + 10, 1'b1);
    for (int i = 0; i < 10 && gb + i < glog.size(); i++)
      check($sformatf("p3_grant%0d", i), glog[gb+i].db, (i % 5) != 4);
    cpu_mode = 0; db_mode = 0;
    repeat (40) tick();

    // Memory never answers: timeout, then a normal transaction
    forced_lat = NEVER; d0 = db_done; t0 = to_cnt;
    db_address = 12'o0005; db_write_enable = 1'b0; db_mem_load = 1'b1;
    repeat (20) tick();
    check("p4_ready_pulses", db_done - d0, 1);
    check("p4_read_data_zero", last_db_rd, 12'o0000);
    check("p4_timeout_pulses", to_cnt - t0, 1);
    forced_lat = 3; d0 = cpu_done;
    cpu_address = 12'o0200; cpu_write_enable = 1'b0; cpu_mem_load = 1'b1;
    repeat (15) tick();
    check("p4_next_ready", cpu_done - d0, 1);
    check("p4_next_read_data", last_cpu_rd, 12'o7402);
    check("p4_next_no_timeout", to_cnt - t0, 1);

    // Reset while waiting on memory
    forced_lat = NEVER; gb = glog.size(); d0 = cpu_done;
    cpu_address = 12'o0400; cpu_write_enable = 1'b0; cpu_mem_load = 1'b1;
    for (int i = 0; i < 10 && glog.size() == gb; i++) tick();
    check("p5_started", glog.size() - gb, 1);
    repeat (2) tick();
    #2 nrst = 1'b0;
    #1;
    check("p5_async_reset_outputs", all_outs(), 55'd0);
    repeat (3) tick();
    check("p5_no_ready_in_reset", cpu_done - d0, 0);
    nrst = 1'b1; forced_lat = 2;
    tick();
    check("p5_mem_load_after_release", mem_load, 1'b1);
    repeat (10) tick();
    check("p5_ready_after_release", cpu_done - d0, 1);

    // Randomized traffic on both ports
    forced_lat = 0; cpu_mode = 1; db_mode = 1;
    repeat (3000) tick();
    cpu_mode = 0; db_mode = 0;
    repeat (40) tick();
    check("scoreboard_drained", rd_idx, exp_q.size());
    check("final_idle", {cpu_mem_load, db_mem_load, busy}, 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
